// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg: widths, gain limit, output FSM encoding and gain multiply helper
// Revision: 1.0
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 32;
    localparam int GAIN_W   = 8;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } out_state_t;

    // Signed sample times unsigned gain, floor-divided by 256; always fits SAMPLE_W.
    function automatic logic signed [SAMPLE_W-1:0] apply_gain(
        input logic signed [SAMPLE_W-1:0] s,
        input logic        [GAIN_W-1:0]   g
    );
        logic signed [SAMPLE_W+GAIN_W-1:0] a;
        logic signed [SAMPLE_W+GAIN_W-1:0] b;
        logic signed [SAMPLE_W+GAIN_W-1:0] p;
        a = {{GAIN_W{s[SAMPLE_W-1]}}, s};
        b = {{SAMPLE_W{1'b0}}, g};
        p = a * b;
        return SAMPLE_W'(p >>> GAIN_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// sample_fifo: synchronous FIFO with combinational head, full/empty and count
// Revision: 1.0
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_out_streamer.sv
`default_nettype none
// ============================================================================
// audio_out_streamer: gain-ramped sample capture, FIFO buffering, codec writes
// Revision: 1.0
// ============================================================================
module audio_out_streamer
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV = 1042,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [31:0]         sound,
    input  logic                mute,
    input  logic                clear_overflow,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                muted,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int CNT_W      = $clog2(SAMPLE_DIV);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]      r_tick_cnt;
    logic [GAIN_W-1:0]     r_gain;
    out_state_t            r_state;
    logic                  r_write;
    logic [SAMPLE_W-1:0]   r_chan;
    logic                  r_overflow;
    logic [DROP_W-1:0]     r_drop_count;

    logic                  w_tick;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [SAMPLE_W-1:0]   w_sample;
    logic [SAMPLE_W-1:0]   w_fifo_head;
    logic [FIFO_CNT_W-1:0] w_unused_fifo_count;

    assign w_tick   = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign w_sample = apply_gain(sound, r_gain);
    assign w_pop    = (r_state == ST_IDLE) && !w_fifo_empty && audio_out_allowed;
    assign w_drop   = w_tick && w_fifo_full && !w_pop;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .i_push  (w_tick),
        .i_pop   (w_pop),
        .i_din   (w_sample),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_unused_fifo_count)
    );

    // The sample above uses the pre-update gain, so the ramp lags by one tick.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
            r_gain     <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            if (!mute && r_gain != GAIN_MAX) begin
                r_gain <= r_gain + 1'b1;
            end else if (mute && r_gain != '0) begin
                r_gain <= r_gain - 1'b1;
            end
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_drop && r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    // HOLD gives the codec one cycle to update allowed before it is sampled again.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_chan  <= '0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_WRITE;
                        r_write <= 1'b1;
                        r_chan  <= w_fifo_head;
                    end
                end
                ST_WRITE: r_state <= ST_HOLD;
                ST_HOLD:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign write_audio_out         = r_write;
    assign left_channel_audio_out  = r_chan;
    assign right_channel_audio_out = r_chan;
    assign muted                   = (r_gain == '0);
    assign overflow                = r_overflow;
    assign drop_count              = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_audio_out_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_audio_out_streamer: directed checks of ramp, scaling, overflow and reset
// Revision: 1.0
// ============================================================================
module tb_audio_out_streamer;

    localparam int SAMPLE_DIV = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DROP_W     = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [31:0]       sound = '0;
    logic              mute = 1'b0;
    logic              clear_overflow = 1'b0;
    logic              allowed = 1'b0;
    logic              write_audio_out;
    logic [31:0]       left_out;
    logic [31:0]       right_out;
    logic              muted;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    audio_out_streamer #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_W     (DROP_W)
    ) dut (
        .CLOCK_50                (clk),
        .resetn                  (resetn),
        .sound                   (sound),
        .mute                    (mute),
        .clear_overflow          (clear_overflow),
        .audio_out_allowed       (allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .muted                   (muted),
        .overflow                (overflow),
        .drop_count              (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Steps negedges until a strobe is seen; waited = negedges consumed, -1 on timeout.
    task automatic get_write(input int budget, output logic [31:0] val_l,
                             output logic [31:0] val_r, output int waited);
        val_l  = '0;
        val_r  = '0;
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (write_audio_out === 1'b1) begin
                val_l  = left_out;
                val_r  = right_out;
                waited = i;
                return;
            end
        end
        check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_strobe"},   32'(write_audio_out), 32'd0);
        check({tag, "_left"},     left_out,             32'd0);
        check({tag, "_right"},    right_out,            32'd0);
        check({tag, "_muted"},    32'(muted),           32'd1);
        check({tag, "_overflow"}, 32'(overflow),        32'd0);
        check({tag, "_drops"},    32'(drop_count),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] l;
        logic [31:0] r;
        int          w;
        int          e;

        // Ramp up from reset with a constant input.
        sound   = 32'h0100_0000;
        allowed = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("rst1");
        resetn = 1'b1;
        for (int k = 0; k < 260; k++) begin
            get_write(20, l, r, w);
            e = ((k < 255) ? k : 255) * 65536;
            check("ramp_up_left", l, 32'(e));
            check("ramp_up_right", r, 32'(e));
        end

        // Mute ramp down from full gain.
        mute = 1'b1;
        for (int j = 0; j < 260; j++) begin
            get_write(20, l, r, w);
            e = ((j < 255) ? (255 - j) : 0) * 65536;
            check("ramp_down_left", l, 32'(e));
            check("ramp_down_right", r, 32'(e));
            check("muted_flag", 32'(muted), (j >= 254) ? 32'd1 : 32'd0);
        end

        // Negative and extreme scaling.
        mute  = 1'b0;
        sound = 32'hFFFF_FF00;
        for (int j = 0; j < 256; j++) begin
            get_write(20, l, r, w);
            if (j == 0)   check("neg_gain0",   l, 32'h0000_0000);
            if (j == 1)   check("neg_gain1",   l, 32'hFFFF_FFFF);
            if (j == 128) check("neg_gain128", l, 32'hFFFF_FF80);
            if (j == 255) check("neg_gain255", l, 32'hFFFF_FF01);
        end
        sound = 32'h8000_0000;
        get_write(20, l, r, w);
        check("min_int_left", l, 32'h8080_0000);
        check("min_int_right", r, 32'h8080_0000);
        sound = 32'h0000_0123;
        get_write(20, l, r, w);
        check("small_pos", l, 32'h0000_0121);
        sound = 32'hFFFF_FFFF;
        get_write(20, l, r, w);
        check("minus_one", l, 32'hFFFF_FFFF);

        // Overflow: fill the FIFO with allowed low, clear coinciding with a drop.
        resetn  = 1'b0;
        allowed = 1'b0;
        sound   = 32'h0100_0000;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (35) @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("drop_beats_clear", 32'(overflow), 32'd1);
        check("drop_count_1", 32'(drop_count), 32'd1);
        check("no_strobe_blocked", 32'(write_audio_out), 32'd0);
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("clear_no_drop", 32'(overflow), 32'd0);
        check("drop_count_kept", 32'(drop_count), 32'd1);
        repeat (3) @(negedge clk);
        check("overflow_again", 32'(overflow), 32'd1);
        check("drop_count_2", 32'(drop_count), 32'd2);

        // Drain in push order with minimum strobe spacing.
        allowed = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get_write(40, l, r, w);
            check("drain_order", l, 32'(i * 65536));
            check("drain_gap", 32'(w), (i == 0) ? 32'd1 : 32'd3);
        end
        get_write(20, l, r, w);
        check("after_drops", l, 32'h000A_0000);

        // Reset during the strobe cycle discards the buffered samples.
        get_write(20, l, r, w);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_state("rst2");
        resetn = 1'b1;
        get_write(20, l, r, w);
        check("first_after_reset_delay", 32'(w), 32'(SAMPLE_DIV + 1));
        check("first_after_reset_val", l, 32'd0);
        get_write(20, l, r, w);
        check("second_after_reset_delay", 32'(w), 32'(SAMPLE_DIV));
        check("second_after_reset_val", l, 32'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
